// File: rtl/uart_rx_if.sv
// Serial-line and result signals of the UART receiver.
// The master side drives the line and frame configuration; the slave side is the receiver.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_in;
  logic [5:0]            prescale;
  logic                  par_en;
  logic                  par_typ;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;

  modport master (
    output rx_in, prescale, par_en, par_typ,
    input  data_out, data_valid, par_err, stp_err, busy
  );

  modport slave (
    input  rx_in, prescale, par_en, par_typ,
    output data_out, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start detection, 2-of-3 mid-bit voting, LSB-first data,
// optional parity and stop check, one-cycle result pulses.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  uart_rx_if.slave   bus,
  output logic [2:0] state_o
);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [5:0]            p_q, p_d;
  logic [5:0]            edge_q, edge_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  pen_q, pen_d;
  logic                  ptyp_q, ptyp_d;
  logic                  s0_q, s0_d;
  logic                  s1_q, s1_d;
  logic                  vote_q, vote_d;
  logic                  mis_q, mis_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;
  logic [5:0]            half;
  logic [5:0]            p_sel;
  logic                  bit_end;

  assign half    = p_q >> 1;
  assign bit_end = (edge_q == (p_q - 6'd1));
  assign p_sel   = ((bus.prescale == 6'd16) || (bus.prescale == 6'd32)) ? bus.prescale : 6'd8;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      edge_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      pen_q   <= 1'b0;
      ptyp_q  <= 1'b0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      vote_q  <= 1'b1;
      mis_q   <= 1'b0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      pen_q   <= pen_d;
      ptyp_q  <= ptyp_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      vote_q  <= vote_d;
      mis_q   <= mis_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      serr_q  <= serr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    edge_d  = bit_end ? 6'd0 : (edge_q + 6'd1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    vote_d  = vote_q;
    mis_d   = mis_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    serr_d  = 1'b0;

    // Three samples straddle the bit centre; the vote is ready well before bit end.
    if (state_q != S_IDLE) begin
      if (edge_q == (half - 6'd1)) s0_d = rx_s_q;
      if (edge_q == half)          s1_d = rx_s_q;
      if (edge_q == (half + 6'd1)) vote_d = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
    end

    case (state_q)
      S_IDLE: begin
        edge_d = 6'd0;
        if (!rx_s_q) begin
          state_d = S_START;
          p_d     = p_sel;
          pen_d   = bus.par_en;
          ptyp_d  = bus.par_typ;
          bit_d   = '0;
          mis_d   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) state_d = vote_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {vote_q, shift_q[DATA_WIDTH-1:1]};
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = pen_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          mis_d   = (vote_q != ((^shift_q) ^ ptyp_q));
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          perr_d  = mis_q;
          serr_d  = ~vote_q;
          if (vote_q && !mis_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.par_err    = perr_q;
  assign bus.stp_err    = serr_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign state_o        = state_q;
endmodule
